// File: rtl/deskew_pkg.sv
// Shared constants and state encoding for the Deskew host-side controller.
// Contents:
//   WIDTH, ADDR_W        default pixel and BRAM address widths
//   IMG_PIXELS           pixels in one 28x28 image
//   OUT_BASE             BRAM word holding deskewed pixel 0
//   host_state_t         controller FSM states
package deskew_pkg;

  localparam int WIDTH      = 16;
  localparam int ADDR_W     = 11;
  localparam int IMG_PIXELS = 784;
  localparam int OUT_BASE   = 784;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    KICK   = 3'd2,
    RUN    = 3'd3,
    UNLOAD = 3'd4
  } host_state_t;

endpackage

// File: rtl/deskew_host_ctrl_if.sv
// Bundle of the pixel streams, BRAM port A and the Deskew start/ready pair.
// Modports:
//   master  the host controller (drives s_ready, m_*, bram_* requests, dskw_start)
//   slave   the surroundings (drives s_data/s_valid, m_ready, bram_dout, dskw_ready)
interface deskew_host_ctrl_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 11
);

  logic [WIDTH-1:0]  s_data;
  logic              s_valid;
  logic              s_ready;
  logic [WIDTH-1:0]  m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic [ADDR_W-1:0] bram_addr;
  logic [WIDTH-1:0]  bram_din;
  logic [WIDTH-1:0]  bram_dout;
  logic              bram_en;
  logic              bram_we;
  logic              dskw_start;
  logic              dskw_ready;

  modport master (
    input  s_data, s_valid, m_ready, bram_dout, dskw_ready,
    output s_ready, m_data, m_valid, m_last, bram_addr, bram_din, bram_en, bram_we, dskw_start
  );

  modport slave (
    output s_data, s_valid, m_ready, bram_dout, dskw_ready,
    input  s_ready, m_data, m_valid, m_last, bram_addr, bram_din, bram_en, bram_we, dskw_start
  );

endinterface

// File: rtl/deskew_host_ctrl_skid_fifo.sv
// Two-entry FIFO that absorbs the one-cycle BRAM read latency on the output stream.
// Ports:
//   clk, reset  clock and asynchronous active-low reset (FIFO empties)
//   push, din   write an entry (caller guarantees space)
//   pop         drop the head entry (caller guarantees non-empty)
//   dout        head entry
//   count       number of entries held (0..2)
module dskw_skid_fifo #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] mem_r [2];
  logic         wr_ptr_r;
  logic         rd_ptr_r;
  logic [1:0]   count_r;

  // Storage, pointers and occupancy; push and pop together leave count unchanged
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_r[0] <= {W{1'b0}};
      mem_r[1] <= {W{1'b0}};
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/deskew_host_ctrl.sv
// Host-side controller for the Deskew engine. Streams one image into BRAM
// words 0..IMG_PIXELS-1 through port A, kicks Deskew, waits for it to finish,
// then reads words OUT_BASE.. back out as a pixel stream with m_last on the
// final pixel. Pixel data passes through untouched.
// Ports:
//   clk, reset  clock and asynchronous active-low reset (all outputs 0)
//   bus         pixel streams, BRAM port A and Deskew start/ready (master side)
//   busy        high in every state except IDLE
module deskew_host_ctrl #(
  parameter int WIDTH      = deskew_pkg::WIDTH,
  parameter int ADDR_W     = deskew_pkg::ADDR_W,
  parameter int IMG_PIXELS = deskew_pkg::IMG_PIXELS,
  parameter int OUT_BASE   = deskew_pkg::OUT_BASE
) (
  input  logic                clk,
  input  logic                reset,
  deskew_host_ctrl_if.master  bus,
  output logic                busy
);

  import deskew_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(IMG_PIXELS - 1);
  localparam logic [ADDR_W-1:0] CNT_A  = ADDR_W'(IMG_PIXELS);
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(OUT_BASE);
  localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);

  host_state_t       state_r;
  host_state_t       state_s;
  logic [ADDR_W-1:0] wr_cnt_r;
  logic [ADDR_W-1:0] rd_cnt_r;
  logic              s_ready_r;
  logic              inflight_r;
  logic              inflight_last_r;

  logic              wr_fire_s;
  logic              rd_issue_s;
  logic              pop_s;
  logic              m_valid_s;
  logic              head_last_s;
  logic [2:0]        occupancy_s;
  logic [WIDTH:0]    fifo_dout_s;
  logic [1:0]        fifo_count_s;

  // s_ready_r is only ever high in IDLE/LOAD, so it alone qualifies a write
  assign wr_fire_s   = s_ready_r & bus.s_valid;
  assign m_valid_s   = (fifo_count_s != 2'd0);
  assign head_last_s = fifo_dout_s[WIDTH];
  assign pop_s       = m_valid_s & bus.m_ready;

  // Entries the FIFO will hold once the in-flight read lands, net of this
  // cycle's pop. Crediting the pop keeps one read per clock when m_ready is
  // held high; without it the stream would bubble every third cycle.
  assign occupancy_s = {1'b0, fifo_count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
  assign rd_issue_s  = (state_r == UNLOAD) && (rd_cnt_r < CNT_A) && (occupancy_s < 3'd2);

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, LOAD: begin
        if (wr_fire_s && (wr_cnt_r == LAST_A)) state_s = KICK;
        else if (wr_fire_s)                    state_s = LOAD;
        else                                   state_s = state_r;
      end
      KICK: begin
        if (!bus.dskw_ready) state_s = RUN;
        else                 state_s = KICK;
      end
      RUN: begin
        if (bus.dskw_ready) state_s = UNLOAD;
        else                state_s = RUN;
      end
      UNLOAD: begin
        if (pop_s && head_last_s) state_s = IDLE;
        else                      state_s = UNLOAD;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, counters, registered s_ready and read-in-flight tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r         <= IDLE;
      wr_cnt_r        <= {ADDR_W{1'b0}};
      rd_cnt_r        <= {ADDR_W{1'b0}};
      s_ready_r       <= 1'b0;
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      s_ready_r <= (state_s == IDLE) || (state_s == LOAD);
      if (wr_fire_s) begin
        wr_cnt_r <= (wr_cnt_r == LAST_A) ? {ADDR_W{1'b0}} : (wr_cnt_r + ONE_A);
      end
      if (state_s != UNLOAD) begin
        rd_cnt_r <= {ADDR_W{1'b0}};
      end else if (rd_issue_s) begin
        rd_cnt_r <= rd_cnt_r + ONE_A;
      end
      // The last-pixel tag travels with the read so the FIFO entry carries it
      inflight_r      <= rd_issue_s;
      inflight_last_r <= rd_issue_s && (rd_cnt_r == LAST_A);
    end
  end

  dskw_skid_fifo #(.W(WIDTH + 1)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight_r),
    .din   ({inflight_last_r, bus.bram_dout}),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .count (fifo_count_s)
  );

  // Port A drive: load writes take priority; idle port presents all zeros
  always_comb begin
    bus.bram_en   = 1'b0;
    bus.bram_we   = 1'b0;
    bus.bram_addr = {ADDR_W{1'b0}};
    bus.bram_din  = {WIDTH{1'b0}};
    if (wr_fire_s) begin
      bus.bram_en   = 1'b1;
      bus.bram_we   = 1'b1;
      bus.bram_addr = wr_cnt_r;
      bus.bram_din  = bus.s_data;
    end else if (rd_issue_s) begin
      bus.bram_en   = 1'b1;
      bus.bram_addr = BASE_A + rd_cnt_r;
    end else begin
      bus.bram_en   = 1'b0;
    end
  end

  assign bus.s_ready    = s_ready_r;
  assign bus.m_valid    = m_valid_s;
  assign bus.m_data     = m_valid_s ? fifo_dout_s[WIDTH-1:0] : {WIDTH{1'b0}};
  assign bus.m_last     = m_valid_s & head_last_s;
  assign bus.dskw_start = (state_r == KICK);
  assign busy           = (state_r != IDLE);

endmodule
